// File: rtl/decode_stage_pkg.sv
// Decode stage shared definitions: opcode constants, instruction formats,
// FSM states and the opcode-to-format lookup used by decode_stage.
package decode_stage_pkg;

  localparam logic [4:0] OP_HALT  = 5'b00000;
  localparam logic [4:0] OP_NOP   = 5'b00001;
  localparam logic [4:0] OP_J     = 5'b00100;
  localparam logic [4:0] OP_JR    = 5'b00101;
  localparam logic [4:0] OP_JAL   = 5'b00110;
  localparam logic [4:0] OP_JALR  = 5'b00111;
  localparam logic [4:0] OP_ADDI  = 5'b01000;
  localparam logic [4:0] OP_SUBI  = 5'b01001;
  localparam logic [4:0] OP_XORI  = 5'b01010;
  localparam logic [4:0] OP_ANDNI = 5'b01011;
  localparam logic [4:0] OP_BEQZ  = 5'b01100;
  localparam logic [4:0] OP_BNEZ  = 5'b01101;
  localparam logic [4:0] OP_BLTZ  = 5'b01110;
  localparam logic [4:0] OP_BGEZ  = 5'b01111;
  localparam logic [4:0] OP_ST    = 5'b10000;
  localparam logic [4:0] OP_LD    = 5'b10001;
  localparam logic [4:0] OP_SLBI  = 5'b10010;
  localparam logic [4:0] OP_STU   = 5'b10011;
  localparam logic [4:0] OP_ROLI  = 5'b10100;
  localparam logic [4:0] OP_SLLI  = 5'b10101;
  localparam logic [4:0] OP_RORI  = 5'b10110;
  localparam logic [4:0] OP_SRLI  = 5'b10111;
  localparam logic [4:0] OP_LBI   = 5'b11000;
  localparam logic [4:0] OP_BTR   = 5'b11001;
  localparam logic [4:0] OP_SHIFT = 5'b11010;
  localparam logic [4:0] OP_ADD   = 5'b11011;
  localparam logic [4:0] OP_SEQ   = 5'b11100;
  localparam logic [4:0] OP_SLT   = 5'b11101;
  localparam logic [4:0] OP_SLE   = 5'b11110;
  localparam logic [4:0] OP_SCO   = 5'b11111;

  typedef enum logic [1:0] {FMT_R, FMT_I1, FMT_I2, FMT_J} fmt_e;

  typedef enum logic {ST_RUN, ST_HALTED} state_e;

  typedef struct packed {
    logic legal;
    fmt_e fmt;
  } op_info_t;

  // Unknown opcodes report legal=0 and fall back to R format.
  function automatic op_info_t op_info(input logic [4:0] op);
    op_info_t r;
    r.legal = 1'b1;
    r.fmt   = FMT_R;
    case (op)
      OP_HALT, OP_NOP, OP_BTR, OP_SHIFT, OP_ADD,
      OP_SEQ, OP_SLT, OP_SLE, OP_SCO:                 r.fmt = FMT_R;
      OP_ADDI, OP_SUBI, OP_XORI, OP_ANDNI, OP_ST, OP_LD,
      OP_STU, OP_ROLI, OP_SLLI, OP_RORI, OP_SRLI:     r.fmt = FMT_I1;
      OP_JR, OP_JALR, OP_BEQZ, OP_BNEZ, OP_BLTZ,
      OP_BGEZ, OP_SLBI, OP_LBI:                       r.fmt = FMT_I2;
      OP_J, OP_JAL:                                   r.fmt = FMT_J;
      default:                                        r.legal = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/decode_stage_rf.sv
// 8-entry register file, two combinational read ports, one write port.
// With DECODE_STAGE_BYPASS_EN defined, a read of the register being written
// in the same cycle returns the incoming write data.
module decode_stage_rf #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [2:0]        wr_sel,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [2:0]        rd_sel_a,
  input  logic [2:0]        rd_sel_b,
  output logic [DATA_W-1:0] rd_a,
  output logic [DATA_W-1:0] rd_b
);

  logic [DATA_W-1:0] regs [8];

  // Register storage; writes are independent of pipeline state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) regs[i] <= '0;
    end else if (wr_en) begin
      regs[wr_sel] <= wr_data;
    end
  end

  // Read ports, optionally forwarding the same-cycle write.
  always_comb begin
`ifdef DECODE_STAGE_BYPASS_EN
    rd_a = (wr_en && (wr_sel == rd_sel_a)) ? wr_data : regs[rd_sel_a];
    rd_b = (wr_en && (wr_sel == rd_sel_b)) ? wr_data : regs[rd_sel_b];
`else
    rd_a = regs[rd_sel_a];
    rd_b = regs[rd_sel_b];
`endif
  end

endmodule

// File: rtl/decode_stage.sv
// Decode stage: accepts 16-bit instructions, reads operands, decodes format
// and immediate, and presents a registered bundle one cycle later.
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high; a held bundle stays stable until out_ready is seen.
// The RUN/HALTED FSM state is visible on the halted output.
// Optional macro DECODE_STAGE_BYPASS_EN enables write-before-read in the
// register file.
module decode_stage
  import decode_stage_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int ILLEGAL_ERR = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [15:0]       instr,
  input  logic              wb_en,
  input  logic [2:0]        wb_sel,
  input  logic [DATA_W-1:0] wb_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_a,
  output logic [DATA_W-1:0] out_b,
  output logic [DATA_W-1:0] out_imm,
  output logic [2:0]        out_wr_sel,
  output logic [4:0]        out_opcode,
  output logic [1:0]        out_funct,
  output logic              out_dump,
  output logic              halted,
  output logic              err
);

  state_e            state, state_next;
  op_info_t          info;
  logic              accept;
  logic              is_halt;
  logic [DATA_W-1:0] rd_a, rd_b;
  logic [DATA_W-1:0] dec_imm;
  logic [2:0]        dec_wr_sel;

  assign in_ready = (state == ST_RUN) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign info     = op_info(instr[15:11]);
  assign is_halt  = (instr[15:11] == OP_HALT);
  assign halted   = (state == ST_HALTED);

  decode_stage_rf #(.DATA_W(DATA_W)) u_rf (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wb_en),
    .wr_sel   (wb_sel),
    .wr_data  (wb_data),
    .rd_sel_a (instr[10:8]),
    .rd_sel_b (instr[7:5]),
    .rd_a     (rd_a),
    .rd_b     (rd_b)
  );

  // Destination index and sign-extended immediate by instruction format.
  always_comb begin
    dec_wr_sel = instr[4:2];
    dec_imm    = '0;
    case (info.fmt)
      FMT_I1: begin
        dec_wr_sel = instr[7:5];
        dec_imm    = {{(DATA_W-5){instr[4]}}, instr[4:0]};
      end
      FMT_I2: begin
        dec_wr_sel = instr[10:8];
        dec_imm    = {{(DATA_W-8){instr[7]}}, instr[7:0]};
      end
      FMT_J: begin
        dec_wr_sel = 3'd7;
        dec_imm    = {{(DATA_W-11){instr[10]}}, instr[10:0]};
      end
      default: ;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_RUN;
    else     state <= state_next;
  end

  // FSM next state: HALT accepted in RUN parks the stage until reset.
  always_comb begin
    state_next = state;
    if ((state == ST_RUN) && accept && is_halt) state_next = ST_HALTED;
  end

  // Output bundle register: load on accept, drop valid once consumed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_a      <= '0;
      out_b      <= '0;
      out_imm    <= '0;
      out_wr_sel <= '0;
      out_opcode <= '0;
      out_funct  <= '0;
      out_dump   <= 1'b0;
    end else if (accept) begin
      out_valid  <= 1'b1;
      out_a      <= rd_a;
      out_b      <= rd_b;
      out_imm    <= dec_imm;
      out_wr_sel <= dec_wr_sel;
      out_opcode <= instr[15:11];
      out_funct  <= instr[1:0];
      out_dump   <= is_halt;
    end else if (out_ready) begin
      out_valid  <= 1'b0;
    end
  end

  // Sticky illegal-opcode flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err <= 1'b0;
    end else if (accept && !info.legal && (ILLEGAL_ERR != 0)) begin
      err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: a 16-bit instance (illegal opcodes flagged) and a
// 32-bit instance (illegal opcodes ignored) share the same stimulus and are
// both checked each cycle against a behavioural model.
module tb_decode_stage;

  // ---------------- clock / reset / signals ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        in_valid = 1'b0, out_ready = 1'b0, wb_en = 1'b0;
  logic [15:0] instr = '0, wb_data = '0;
  logic [2:0]  wb_sel = '0;
  logic [31:0] wb_data_w;
  assign wb_data_w = {16'h0000, wb_data};

  logic        in_ready, out_valid, out_dump, halted, err;
  logic [15:0] out_a, out_b, out_imm;
  logic [2:0]  out_wr_sel;
  logic [4:0]  out_opcode;
  logic [1:0]  out_funct;

  logic        in_ready_w, out_valid_w, out_dump_w, halted_w, err_w;
  logic [31:0] out_a_w, out_b_w, out_imm_w;
  logic [2:0]  out_wr_sel_w;
  logic [4:0]  out_opcode_w;
  logic [1:0]  out_funct_w;

  decode_stage #(.DATA_W(16), .ILLEGAL_ERR(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .wb_en(wb_en), .wb_sel(wb_sel), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_a(out_a),
    .out_b(out_b), .out_imm(out_imm), .out_wr_sel(out_wr_sel),
    .out_opcode(out_opcode), .out_funct(out_funct), .out_dump(out_dump),
    .halted(halted), .err(err)
  );

  decode_stage #(.DATA_W(32), .ILLEGAL_ERR(0)) dut_w (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w),
    .instr(instr), .wb_en(wb_en), .wb_sel(wb_sel), .wb_data(wb_data_w),
    .out_valid(out_valid_w), .out_ready(out_ready), .out_a(out_a_w),
    .out_b(out_b_w), .out_imm(out_imm_w), .out_wr_sel(out_wr_sel_w),
    .out_opcode(out_opcode_w), .out_funct(out_funct_w),
    .out_dump(out_dump_w), .halted(halted_w), .err(err_w)
  );

  // ---------------- model state / scoreboard ----------------
  logic [15:0] m_regs [8];
  logic        m_valid, m_halted, m_err, m_dump;
  logic [15:0] m_a, m_b, m_imm;
  logic [31:0] m_imm_w;
  logic [2:0]  m_wr_sel;
  logic [4:0]  m_op;
  logic [1:0]  m_funct;
  logic [15:0] exp_q[$];
  int          total = 0;
  int          bad = 0;
  int          consumed = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Format from the ISA listing: 0=R 1=I1 2=I2 3=J, -1 = not in the ISA.
  function automatic int fmt_of(input logic [4:0] op);
    if (op inside {5'd0, 5'd1, [5'd25:5'd31]})                 return 0;
    if (op inside {[5'd8:5'd11], 5'd16, 5'd17, [5'd19:5'd23]}) return 1;
    if (op inside {5'd5, 5'd7, [5'd12:5'd15], 5'd18, 5'd24})   return 2;
    if (op inside {5'd4, 5'd6})                                return 3;
    return -1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_regs[i] = '0;
    m_valid = 0; m_halted = 0; m_err = 0; m_dump = 0;
    m_a = '0; m_b = '0; m_imm = '0; m_imm_w = '0;
    m_wr_sel = '0; m_op = '0; m_funct = '0;
    exp_q.delete();
  endtask

  // Model step at a rising edge, from the inputs present before the edge.
  task automatic model_step(input logic ready);
    int          f;
    logic [63:0] s;
    if (ready && in_valid) begin
      f = fmt_of(instr[15:11]);
      m_a = m_regs[instr[10:8]];
      m_b = m_regs[instr[7:5]];
`ifdef DECODE_STAGE_BYPASS_EN
      if (wb_en && wb_sel == instr[10:8]) m_a = wb_data;
      if (wb_en && wb_sel == instr[7:5])  m_b = wb_data;
`endif
      case (f)
        1:       begin s = 64'($signed(instr[4:0]));  m_wr_sel = instr[7:5];  end
        2:       begin s = 64'($signed(instr[7:0]));  m_wr_sel = instr[10:8]; end
        3:       begin s = 64'($signed(instr[10:0])); m_wr_sel = 3'd7;        end
        default: begin s = '0;                        m_wr_sel = instr[4:2];  end
      endcase
      m_imm   = s[15:0];
      m_imm_w = s[31:0];
      m_op    = instr[15:11];
      m_funct = instr[1:0];
      m_dump  = (instr[15:11] == 5'd0);
      m_valid = 1;
      if (m_dump) m_halted = 1;
      if (f < 0)  m_err = 1;
      exp_q.push_back(instr);
    end else if (out_ready) begin
      m_valid = 0;
    end
    if (wb_en) m_regs[wb_sel] = wb_data;
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_in(input logic v, input logic [15:0] ins, input logic ordy,
                        input logic we, input logic [2:0] ws, input logic [15:0] wd);
    in_valid = v; instr = ins; out_ready = ordy;
    wb_en = we; wb_sel = ws; wb_data = wd;
  endtask

  // One clock: check ready/scoreboard before the edge, advance the model at
  // the edge, compare registered outputs 1 time unit after it.
  task automatic cycle();
    logic        ready;
    logic [15:0] f;
    #2;
    ready = !m_halted && (!m_valid || out_ready);
    chk("in_ready", 64'(in_ready), 64'(ready));
    chk("in_ready_w", 64'(in_ready_w), 64'(ready));
    if (out_valid && out_ready) begin
      consumed++;
      chk("sb_nonempty", 64'(exp_q.size() != 0), 64'(1'b1));
      if (exp_q.size() != 0) begin
        f = exp_q.pop_front();
        chk("sb_opcode", 64'(out_opcode), 64'(f[15:11]));
        chk("sb_funct", 64'(out_funct), 64'(f[1:0]));
      end
    end
    @(posedge clk);
    model_step(ready);
    #1;
    chk("out_valid", 64'(out_valid), 64'(m_valid));
    chk("halted", 64'(halted), 64'(m_halted));
    chk("err", 64'(err), 64'(m_err));
    chk("out_valid_w", 64'(out_valid_w), 64'(m_valid));
    chk("halted_w", 64'(halted_w), 64'(m_halted));
    chk("err_w", 64'(err_w), 64'(1'b0));
    if (m_valid) begin
      chk("out_a", 64'(out_a), 64'(m_a));
      chk("out_b", 64'(out_b), 64'(m_b));
      chk("out_imm", 64'(out_imm), 64'(m_imm));
      chk("out_wr_sel", 64'(out_wr_sel), 64'(m_wr_sel));
      chk("out_opcode", 64'(out_opcode), 64'(m_op));
      chk("out_funct", 64'(out_funct), 64'(m_funct));
      chk("out_dump", 64'(out_dump), 64'(m_dump));
      chk("out_a_w", 64'(out_a_w), 64'({16'h0000, m_a}));
      chk("out_b_w", 64'(out_b_w), 64'({16'h0000, m_b}));
      chk("out_imm_w", 64'(out_imm_w), 64'(m_imm_w));
      chk("out_wr_sel_w", 64'(out_wr_sel_w), 64'(m_wr_sel));
      chk("out_dump_w", 64'(out_dump_w), 64'(m_dump));
    end
  endtask

  task automatic idle(input int n);
    set_in(1'b0, 16'h0000, 1'b1, 1'b0, 3'd0, 16'h0000);
    repeat (n) cycle();
  endtask

  // Asynchronous reset: outputs must clear before any clock edge.
  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'(1'b0));
    chk("rst_out_dump", 64'(out_dump), 64'(1'b0));
    chk("rst_halted", 64'(halted), 64'(1'b0));
    chk("rst_err", 64'(err), 64'(1'b0));
    chk("rst_fields", 64'({out_a, out_b, out_imm, out_wr_sel, out_opcode, out_funct}), 64'(0));
    chk("rst_out_valid_w", 64'(out_valid_w), 64'(1'b0));
    chk("rst_halted_w", 64'(halted_w), 64'(1'b0));
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("post_rst_in_ready", 64'(in_ready), 64'(1'b1));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [15:0] ins;
    int          c0;
    logic        v, ordy, we;

    model_reset();
    #3;
    do_reset();

    // ADDI r1, r1, 5
    idle(1);
    set_in(1'b1, 16'h4125, 1'b1, 1'b0, 3'd0, 16'h0000);
    cycle();
    chk("addi_valid", 64'(out_valid), 64'(1'b1));
    chk("addi_wr_sel", 64'(out_wr_sel), 64'(3'd1));
    chk("addi_imm", 64'(out_imm), 64'(16'h0005));
    chk("model_addi_imm", 64'(m_imm), 64'(16'h0005));

    // LBI r3, 0xF0
    set_in(1'b1, 16'hC3F0, 1'b1, 1'b0, 3'd0, 16'h0000);
    cycle();
    chk("lbi_imm16", 64'(out_imm), 64'(16'hFFF0));
    chk("lbi_imm32", 64'(out_imm_w), 64'(32'hFFFFFFF0));
    chk("lbi_wr_sel", 64'(out_wr_sel), 64'(3'd3));
    chk("model_lbi_imm32", 64'(m_imm_w), 64'(32'hFFFFFFF0));

    // Backpressure: hold A for 3 cycles while B waits
    idle(1);
    c0 = consumed;
    set_in(1'b1, 16'h4A21, 1'b0, 1'b0, 3'd0, 16'h0000);
    cycle();
    set_in(1'b1, 16'hDB04, 1'b0, 1'b0, 3'd0, 16'h0000);
    repeat (3) begin
      cycle();
      chk("stall_in_ready", 64'(in_ready), 64'(1'b0));
      chk("stall_hold_op", 64'(out_opcode), 64'(5'b01001));
    end
    set_in(1'b1, 16'hDB04, 1'b1, 1'b0, 3'd0, 16'h0000);
    cycle();
    chk("stall_b_op", 64'(out_opcode), 64'(5'b11011));
    idle(3);
    chk("stall_consumed", 64'(consumed - c0), 64'(2));
    chk("stall_drained", 64'(out_valid), 64'(1'b0));

    // Same-cycle writeback vs. operand read of r2
    set_in(1'b0, 16'h0000, 1'b1, 1'b1, 3'd2, 16'hAAAA);
    cycle();
    set_in(1'b1, 16'hDA00, 1'b1, 1'b1, 3'd2, 16'h1234);
    cycle();
`ifdef DECODE_STAGE_BYPASS_EN
    chk("bypass_a", 64'(out_a), 64'(16'h1234));
`else
    chk("nobypass_a", 64'(out_a), 64'(16'hAAAA));
`endif
    set_in(1'b1, 16'hDA00, 1'b1, 1'b0, 3'd0, 16'h0000);
    cycle();
    chk("wb_visible_next", 64'(out_a), 64'(16'h1234));

    // Illegal opcode 00010: err sticky on the flagging instance only
    set_in(1'b1, 16'h101C, 1'b1, 1'b0, 3'd0, 16'h0000);
    cycle();
    chk("illegal_err", 64'(err), 64'(1'b1));
    chk("illegal_err_w", 64'(err_w), 64'(1'b0));
    chk("illegal_wr_sel", 64'(out_wr_sel), 64'(3'd7));
    chk("illegal_imm", 64'(out_imm), 64'(16'h0000));
    idle(4);
    chk("illegal_err_held", 64'(err), 64'(1'b1));

    // HALT, then reset recovery
    do_reset();
    set_in(1'b1, 16'h0000, 1'b1, 1'b0, 3'd0, 16'h0000);
    cycle();
    chk("halt_dump", 64'(out_dump), 64'(1'b1));
    chk("halt_halted", 64'(halted), 64'(1'b1));
    set_in(1'b1, 16'h4125, 1'b1, 1'b1, 3'd5, 16'h5555);
    repeat (3) begin
      cycle();
      chk("halt_in_ready", 64'(in_ready), 64'(1'b0));
    end
    do_reset();
    chk("halt_cleared", 64'(halted), 64'(1'b0));
    set_in(1'b1, 16'h45A0, 1'b1, 1'b0, 3'd0, 16'h0000);
    cycle();
    chk("rst_regs_zero_a", 64'(out_a), 64'(16'h0000));
    chk("rst_regs_zero_b", 64'(out_b), 64'(16'h0000));

    // Random traffic, with occasional resets (including mid-handshake)
    for (int n = 0; n < 3000; n++) begin
      ins = 16'($urandom);
      if (ins[15:11] == 5'd0 && $urandom_range(0, 15) != 0) ins[15:11] = 5'b11011;
      v    = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 3) != 0);
      we   = ($urandom_range(0, 1) != 0);
      set_in(v, ins, ordy, we, 3'($urandom_range(0, 7)), 16'($urandom));
      cycle();
      if ((m_halted && $urandom_range(0, 7) == 0) || $urandom_range(0, 199) == 0)
        do_reset();
    end
    idle(4);
    chk("final_drained", 64'(exp_q.size()), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Watchdog so the run always ends
  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
